// File: rtl/alu_issue.sv
// Execute-issue stage ahead of the ALU: RV32I ALU decode, operand select, 2-entry skid buffer.
// Optional write-back forwarding is compiled in with `define ALU_ISSUE_FWD_EN.
module alu_issue #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_func,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic              out_illegal
);

  typedef struct packed {
    logic [3:0]        func;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              illegal;
  } op_t;

  typedef enum logic [6:0] {
    OPC_R     = 7'b0110011,
    OPC_I     = 7'b0010011,
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111
  } opcode_e;

  op_t  main_op, skid_op, dec_op;
  logic main_valid, skid_valid;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic [XLEN-1:0]   imm_i, imm_u, shamt;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rs1    = REG_AW'(in_inst[19:15]);
  assign rs2    = REG_AW'(in_inst[24:20]);
  assign rd     = REG_AW'(in_inst[11:7]);
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign shamt  = XLEN'(in_inst[24:20]);

  // Register operand sources; x0 overrides forwarding.
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
`ifdef ALU_ISSUE_FWD_EN
    if (wb_en && (wb_rd != '0) && (wb_rd == rs1)) rs1_val = wb_data;
    if (wb_en && (wb_rd != '0) && (wb_rd == rs2)) rs2_val = wb_data;
`endif
    if (rs1 == '0) rs1_val = '0;
    if (rs2 == '0) rs2_val = '0;
  end

  always_comb begin
    dec_op         = '0;
    dec_op.rd      = rd;
    dec_op.illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_op.func = {in_inst[30], funct3};
        dec_op.op1  = rs1_val;
        dec_op.op2  = rs2_val;
      end
      OPC_I: begin
        dec_op.func = {(funct3 == 3'b101) & in_inst[30], funct3};
        dec_op.op1  = rs1_val;
        dec_op.op2  = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
      end
      OPC_LUI: begin
        dec_op.op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec_op.op1 = in_pc;
        dec_op.op2 = imm_u;
      end
      default: dec_op.illegal = 1'b1;
    endcase
    dec_op.wen = !dec_op.illegal && (rd != '0);
  end

  logic accept, drain;
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  // Main holds while stalled; a freed main slot takes skid first to keep FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_op    <= '0;
      skid_op    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_valid && !drain) begin
      if (accept) begin
        skid_op    <= dec_op;
        skid_valid <= 1'b1;
      end
    end else if (skid_valid) begin
      main_op    <= skid_op;
      main_valid <= 1'b1;
      skid_valid <= 1'b0;
    end else if (accept) begin
      main_op    <= dec_op;
      main_valid <= 1'b1;
    end else begin
      main_valid <= 1'b0;
    end
  end

  assign out_valid   = main_valid;
  assign out_func    = main_op.func;
  assign out_op1     = main_op.op1;
  assign out_op2     = main_op.op2;
  assign out_rd      = main_op.rd;
  assign out_wen     = main_op.wen;
  assign out_illegal = main_op.illegal;

endmodule
